// File: rtl/clk_div_pkg.sv
// Shared constants for the multi-channel clock divider.
package clk_div_pkg;

  localparam int DIV_MIN    = 2;
  localparam int DIV_10KHZ  = 200;
  localparam int DIV_100KHZ = 20;
  localparam int DIV_1KHZ   = 2000;  // needs CNT_W >= 11
  localparam int CLK_SYS_HZ = 2_000_000;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// Control and output bundle of clk_div_multi; master drives, slave is the divider.
interface clk_div_multi_if #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 8
) ();
  localparam int CH_W = clk_div_pkg::ch_width(NUM_CH);

  logic [NUM_CH-1:0] en;
  logic              sync;
  logic              div_wr;
  logic [CH_W-1:0]   div_ch;
  logic [CNT_W-1:0]  div_val;
  logic [NUM_CH-1:0] div_pend;
  logic              div_err;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;

  modport master (
    output en, sync, div_wr, div_ch, div_val,
    input  div_pend, div_err, clk_out, tick
  );

  modport slave (
    input  en, sync, div_wr, div_ch, div_val,
    output div_pend, div_err, clk_out, tick
  );
endinterface

// File: rtl/clk_div_channel.sv
// One divider channel: period counter, active/shadow divisor, clk_out and tick.
module clk_div_channel #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 200
) (
  input  logic             clk_2MHz,
  input  logic             reset,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_val,
  output logic             pend,
  output logic             clk_out,
  output logic             tick
);
  logic [CNT_W-1:0] active_div;
  logic [CNT_W-1:0] shadow;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_inc;
  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] last;

  assign count_inc = count + CNT_W'(1);
  assign half      = active_div >> 1;
  assign last      = active_div - CNT_W'(1);

  always_ff @(posedge clk_2MHz or posedge reset) begin
    if (reset) begin
      active_div <= CNT_W'(DEFAULT_DIV);
      count      <= CNT_W'(DEFAULT_DIV - 1);
      shadow     <= '0;
      pend       <= 1'b0;
      clk_out    <= 1'b0;
      tick       <= 1'b0;
    end else begin
      if (!en) begin
        tick    <= 1'b0;
        clk_out <= 1'b0;
        // Parked at last count of the (possibly new) divisor so re-enable wraps at once.
        if (pend) begin
          active_div <= shadow;
          count      <= shadow - CNT_W'(1);
          pend       <= 1'b0;
        end else begin
          count <= last;
        end
      end else if (sync || count == last) begin
        count   <= '0;
        tick    <= 1'b1;
        clk_out <= 1'b1;
        if (pend) begin
          active_div <= shadow;
          pend       <= 1'b0;
        end
      end else begin
        count   <= count_inc;
        tick    <= 1'b0;
        clk_out <= (count_inc < half);
      end
      // A write on a boundary edge lands after the apply above and waits for the next one.
      if (wr) begin
        shadow <= wr_val;
        pend   <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: write decode/validation plus NUM_CH channels.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 200
) (
  input  logic            clk_2MHz,
  input  logic            reset,
  clk_div_multi_if.slave  bus
);
  localparam int CH_W = ch_width(NUM_CH);

  logic              wr_ok;
  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] clk_o;
  logic [NUM_CH-1:0] tick_o;
  logic              err_q;

  assign wr_ok = (32'(bus.div_ch) < 32'(NUM_CH)) && (bus.div_val >= CNT_W'(DIV_MIN));

  always_ff @(posedge clk_2MHz or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= bus.div_wr && !wr_ok;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk_2MHz (clk_2MHz),
      .reset    (reset),
      .en       (bus.en[i]),
      .sync     (bus.sync),
      .wr       (bus.div_wr && wr_ok && (bus.div_ch == CH_W'(i))),
      .wr_val   (bus.div_val),
      .pend     (pend[i]),
      .clk_out  (clk_o[i]),
      .tick     (tick_o[i])
    );
  end

  assign bus.div_pend = pend;
  assign bus.clk_out  = clk_o;
  assign bus.tick     = tick_o;
  assign bus.div_err  = err_q;

endmodule
